// File: rtl/axis_pr_freeze_drain_bridge.sv
// AFU->FIM AXI-Stream bridge that brings every channel to a packet boundary before
// partial reconfiguration, truncating packets that stall past the drain timeout.
module axis_pr_freeze_drain_bridge #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned TDATA_WIDTH   = 512,
  parameter int unsigned TUSER_WIDTH   = 10,
  parameter int unsigned DRAIN_TIMEOUT = 256,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            pr_freeze,
  output logic                            freeze_ack,
  input  logic [NUM_CH-1:0]               s_tvalid,
  output logic [NUM_CH-1:0]               s_tready,
  input  logic [NUM_CH-1:0]               s_tlast,
  input  logic [NUM_CH*TDATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_CH*TUSER_WIDTH-1:0]   s_tuser,
  output logic [NUM_CH-1:0]               m_tvalid,
  output logic [NUM_CH-1:0]               m_tlast,
  input  logic [NUM_CH-1:0]               m_tready,
  output logic [NUM_CH*TDATA_WIDTH-1:0]   m_tdata,
  output logic [NUM_CH*TUSER_WIDTH-1:0]   m_tuser,
  output logic [NUM_CH*CNT_WIDTH-1:0]     drop_cnt,
  output logic [NUM_CH-1:0]               timeout_err
);

  typedef enum logic [1:0] {RUN, DRAIN, TRUNC, FROZEN} chan_state_t;

  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TIMEOUT - 1);

  logic [NUM_CH-1:0] chan_quiet;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    chan_state_t            state;
    logic                   in_pkt;
    logic                   in_pkt_next;
    logic [15:0]            drain_cnt;
    logic                   out_free;
    logic                   accept;
    logic                   mv;
    logic                   ml;
    logic [TDATA_WIDTH-1:0] md;
    logic [TUSER_WIDTH-1:0] mu;
    logic [CNT_WIDTH-1:0]   drops;
    logic                   terr;

    assign out_free    = ~mv | m_tready[c];
    assign s_tready[c] = ~reset & ((state == FROZEN) |
                                   (((state == RUN) | (state == DRAIN)) & out_free));
    assign accept      = s_tvalid[c] & s_tready[c];
    assign in_pkt_next = accept ? ~s_tlast[c] : in_pkt;

    assign m_tvalid[c]                              = mv;
    assign m_tlast[c]                               = ml;
    assign m_tdata[c*TDATA_WIDTH +: TDATA_WIDTH]    = md;
    assign m_tuser[c*TUSER_WIDTH +: TUSER_WIDTH]    = mu;
    assign drop_cnt[c*CNT_WIDTH +: CNT_WIDTH]       = drops;
    assign timeout_err[c]                           = terr;
    assign chan_quiet[c]                            = (state == FROZEN) & ~mv;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state     <= RUN;
        in_pkt    <= 1'b0;
        drain_cnt <= '0;
        mv        <= 1'b0;
        ml        <= 1'b0;
        md        <= '0;
        mu        <= '0;
        drops     <= '0;
        terr      <= 1'b0;
      end else begin
        if (accept && state != FROZEN) begin
          mv <= 1'b1;
          ml <= s_tlast[c];
          md <= s_tdata[c*TDATA_WIDTH +: TDATA_WIDTH];
          mu <= s_tuser[c*TUSER_WIDTH +: TUSER_WIDTH];
        end else if (m_tready[c]) begin
          mv <= 1'b0;
        end

        if (accept && state == FROZEN && drops != '1)
          drops <= drops + CNT_WIDTH'(1);

        in_pkt <= in_pkt_next;

        unique case (state)
          RUN: begin
            if (pr_freeze) begin
              state     <= in_pkt_next ? DRAIN : FROZEN;
              drain_cnt <= '0;
            end
          end
          DRAIN: begin
            if (!pr_freeze)
              state <= RUN;
            else if (accept && s_tlast[c])
              state <= FROZEN;
            else if (drain_cnt == DRAIN_LAST) begin
              state <= TRUNC;
              terr  <= 1'b1;
            end else
              drain_cnt <= drain_cnt + 16'd1;
          end
          TRUNC: begin
            // Injected terminator overrides the output-register drain above.
            if (out_free) begin
              mv     <= 1'b1;
              ml     <= 1'b1;
              md     <= '0;
              mu     <= '0;
              in_pkt <= 1'b0;
              state  <= FROZEN;
            end
          end
          FROZEN: begin
            if (!pr_freeze) begin
              state  <= RUN;
              in_pkt <= 1'b0;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      freeze_ack <= 1'b0;
    else
      freeze_ack <= pr_freeze & (&chan_quiet);
  end

endmodule

// File: tb/tb_axis_pr_freeze_drain_bridge.sv
// Scoreboard bench for axis_pr_freeze_drain_bridge: a behavioural channel model
// predicts output beats, drops, timeouts and freeze_ack; a monitor checks the output stream.
module tb_axis_pr_freeze_drain_bridge;
  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int UW  = 4;
  localparam int DT  = 8;
  localparam int CW  = 3;
  localparam int BW  = 1 + UW + DW;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                pr_freeze = 1'b0;
  logic                freeze_ack;
  logic [NCH-1:0]      s_tvalid = '0;
  logic [NCH-1:0]      s_tready;
  logic [NCH-1:0]      s_tlast = '0;
  logic [NCH*DW-1:0]   s_tdata = '0;
  logic [NCH*UW-1:0]   s_tuser = '0;
  logic [NCH-1:0]      m_tvalid;
  logic [NCH-1:0]      m_tlast;
  logic [NCH-1:0]      m_tready = '0;
  logic [NCH*DW-1:0]   m_tdata;
  logic [NCH*UW-1:0]   m_tuser;
  logic [NCH*CW-1:0]   drop_cnt;
  logic [NCH-1:0]      timeout_err;

  always #5 clk = ~clk;

  axis_pr_freeze_drain_bridge #(
    .NUM_CH(NCH), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .DRAIN_TIMEOUT(DT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .pr_freeze(pr_freeze), .freeze_ack(freeze_ack),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser),
    .drop_cnt(drop_cnt), .timeout_err(timeout_err)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_RUN, M_DRAIN, M_TRUNC, M_FROZEN} mmode_t;
  mmode_t          mode [NCH];
  bit              inpkt [NCH];
  bit              occ [NCH];      // model's view: a beat is sitting in the output stage
  int              dcnt [NCH];
  int              drops [NCH];
  bit              terr [NCH];
  bit              ack_exp = 1'b0;
  logic [BW-1:0]   expq [NCH][$];
  bit              quiet, tr, acc, push, ip;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mode[c] = M_RUN; inpkt[c] = 0; occ[c] = 0; dcnt[c] = 0;
      drops[c] = 0; terr[c] = 0; expq[c].delete();
    end
    ack_exp = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    #1;
    if (reset) model_reset();
    else begin
      check("freeze_ack", freeze_ack, ack_exp);
      quiet = pr_freeze;
      for (int c = 0; c < NCH; c++)
        if (!(mode[c] == M_FROZEN && !occ[c])) quiet = 0;
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("drop_cnt_ch%0d", c), drop_cnt[c*CW +: CW], drops[c]);
        check($sformatf("timeout_err_ch%0d", c), timeout_err[c], terr[c]);
        tr = (mode[c] == M_FROZEN) ? 1'b1 : (mode[c] == M_TRUNC) ? 1'b0 : (!occ[c] || m_tready[c]);
        check($sformatf("s_tready_ch%0d", c), s_tready[c], tr);
        acc  = s_tvalid[c] && tr;
        push = 0;
        ip   = acc ? !s_tlast[c] : inpkt[c];
        if (acc) begin
          if (mode[c] == M_FROZEN) begin
            if (drops[c] < (1 << CW) - 1) drops[c]++;
          end else begin
            expq[c].push_back({s_tlast[c], s_tuser[c*UW +: UW], s_tdata[c*DW +: DW]});
            push = 1;
          end
        end
        case (mode[c])
          M_RUN: if (pr_freeze) begin mode[c] = ip ? M_DRAIN : M_FROZEN; dcnt[c] = 0; end
          M_DRAIN: begin
            if (!pr_freeze) mode[c] = M_RUN;
            else if (acc && s_tlast[c]) mode[c] = M_FROZEN;
            else if (dcnt[c] == DT - 1) begin mode[c] = M_TRUNC; terr[c] = 1; end
            else dcnt[c]++;
          end
          M_TRUNC: if (!occ[c] || m_tready[c]) begin
            expq[c].push_back({1'b1, {UW{1'b0}}, {DW{1'b0}}});
            push = 1; ip = 0; mode[c] = M_FROZEN;
          end
          M_FROZEN: if (!pr_freeze) begin mode[c] = M_RUN; ip = 0; end
        endcase
        occ[c]   = push || (occ[c] && !m_tready[c]);
        inpkt[c] = ip;
      end
      ack_exp = quiet;
    end
  end

  // ---------------- output monitor ----------------
  bit            hold_v [NCH];
  logic [BW-1:0] hold_b [NCH];
  logic [BW-1:0] cur, want;

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) hold_v[c] = 0;
      else begin
        cur = {m_tlast[c], m_tuser[c*UW +: UW], m_tdata[c*DW +: DW]};
        if (hold_v[c] && m_tvalid[c]) check($sformatf("hold_stable_ch%0d", c), cur, hold_b[c]);
        if (hold_v[c] && !m_tvalid[c]) check($sformatf("hold_valid_ch%0d", c), m_tvalid[c], 1);
        if (m_tvalid[c]) begin
          if (expq[c].size() == 0) check($sformatf("spurious_beat_ch%0d", c), m_tvalid[c], 0);
          else if (m_tready[c]) begin
            want = expq[c].pop_front();
            check($sformatf("beat_ch%0d", c), cur, want);
          end
        end
        hold_v[c] = m_tvalid[c] && !m_tready[c];
        hold_b[c] = cur;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic payload(input int c);
    s_tdata[c*DW +: DW] = DW'($urandom);
    s_tuser[c*UW +: UW] = UW'($urandom);
  endtask

  task automatic send(input int c, input bit last);
    s_tvalid[c] = 1'b1; s_tlast[c] = last; payload(c);
    for (int i = 0; i < 50; i++) begin
      #1;
      if (s_tready[c]) begin @(posedge clk); #1; s_tvalid[c] = 1'b0; return; end
      @(posedge clk); #1;
    end
    check($sformatf("send_accept_ch%0d", c), s_tready[c], 1);
    s_tvalid[c] = 1'b0;
  endtask

  task automatic hard_reset();
    reset = 1'b1; cyc(2); reset = 1'b0; cyc(1);
  endtask

  initial begin
    #2;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_freeze_ack", freeze_ack, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_timeout_err", timeout_err, 0);
    cyc(2); reset = 1'b0; m_tready = '1; cyc(2);

    // idle freeze: ack two cycles after request
    pr_freeze = 1'b1; cyc(2);
    check("idle_freeze_ack", freeze_ack, 1);
    check("idle_drop_cnt", drop_cnt, 0);
    pr_freeze = 1'b0; cyc(3);

    // drain to packet boundary on ch0
    send(0, 0); send(0, 0); pr_freeze = 1'b1; send(0, 0); send(0, 1); cyc(4);
    check("drain_freeze_ack", freeze_ack, 1);
    check("drain_timeout_err", timeout_err, 0);
    pr_freeze = 1'b0; cyc(3);

    // freeze abort under backpressure on ch1
    m_tready = '0; send(1, 0); pr_freeze = 1'b1; cyc(3); pr_freeze = 1'b0; cyc(1);
    m_tready = '1; send(1, 0); send(1, 1); cyc(3);
    check("abort_freeze_ack", freeze_ack, 0);

    // frozen discard and counter saturation
    hard_reset(); pr_freeze = 1'b1; cyc(2);
    s_tvalid[0] = 1'b1; s_tlast[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin payload(0); cyc(); end
    s_tvalid[0] = 1'b0;
    check("discard_drop5", drop_cnt[CW-1:0], 5);
    check("discard_m_tvalid", m_tvalid, 0);
    s_tvalid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin payload(0); cyc(); end
    s_tvalid[0] = 1'b0;
    check("discard_drop_sat", drop_cnt[CW-1:0], 7);
    pr_freeze = 1'b0; cyc(2);
    check("drop_kept_on_exit", drop_cnt[CW-1:0], 7);

    // drain timeout completes with a truncation beat
    hard_reset(); send(0, 0); pr_freeze = 1'b1; cyc(DT + 6);
    check("timeout_err_set", timeout_err, 2'b01);
    check("timeout_freeze_ack", freeze_ack, 1);
    pr_freeze = 1'b0; cyc(2);
    check("timeout_err_sticky", timeout_err, 2'b01);

    // async reset while stuck in truncation
    hard_reset(); m_tready = '0; send(0, 0); pr_freeze = 1'b1; cyc(DT + 4);
    check("trunc_timeout_err", timeout_err, 2'b01);
    #2 reset = 1'b1;
    #1;
    check("trunc_rst_m_tvalid", m_tvalid, 0);
    check("trunc_rst_s_tready", s_tready, 0);
    check("trunc_rst_timeout_err", timeout_err, 0);
    check("trunc_rst_m_tlast", m_tlast, 0);
    cyc(1); pr_freeze = 1'b0; reset = 1'b0; m_tready = '1; cyc(6);
    check("trunc_no_inject", m_tvalid, 0);

    // randomized traffic with random freeze windows
    hard_reset();
    for (int seg = 0; seg < 120; seg++) begin
      pr_freeze = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < int'($urandom_range(1, 30)); i++) begin
        for (int c = 0; c < NCH; c++) begin
          s_tvalid[c] = 1'($urandom_range(0, 1));
          s_tlast[c]  = ($urandom_range(0, 3) == 0);
          m_tready[c] = ($urandom_range(0, 3) != 0);
          payload(c);
        end
        cyc();
      end
    end
    s_tvalid = '0; pr_freeze = 1'b0; m_tready = '1; cyc(5);
    for (int c = 0; c < NCH; c++)
      check($sformatf("queue_empty_ch%0d", c), expq[c].size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axis_pr_freeze_drain_bridge.md
AXIS_PR_FREEZE_DRAIN_BRIDGE -- requirements
Module: axis_pr_freeze_drain_bridge

Interface
REQ-001 Parameter: NUM_CH, default 2, number of independent AXI-S channels (AFU to FIM direction).
REQ-002 Parameter: TDATA_WIDTH, default 512, tdata width per channel.
REQ-003 Parameter: TUSER_WIDTH, default 10, tuser width per channel.
REQ-004 Parameter: DRAIN_TIMEOUT, default 256, maximum drain cycles before forced truncation; legal range 2 to 65535.
REQ-005 Parameter: CNT_WIDTH, default 16, width of the per-channel dropped-beat counter.
REQ-006 Port: clk, input, 1, single clock for all logic.
REQ-007 Port: reset, input, 1, asynchronous active-high reset.
REQ-008 Port: pr_freeze, input, 1, freeze request level, synchronous to clk.
REQ-009 Port: freeze_ack, output, 1, all channels frozen and all output registers empty.
REQ-010 Ports: s_tvalid, s_tready, s_tlast, with s_tvalid and s_tlast as inputs, s_tready as output, each NUM_CH wide, AFU-side handshake (one bit per channel).
REQ-011 Ports: s_tdata, input, NUM_CH*TDATA_WIDTH; s_tuser, input, NUM_CH*TUSER_WIDTH; AFU-side payload, channel c at slice c.
REQ-012 Ports: m_tvalid, m_tlast, outputs, NUM_CH; m_tready, input, NUM_CH; m_tdata, output, NUM_CH*TDATA_WIDTH; m_tuser, output, NUM_CH*TUSER_WIDTH; FIM-side.
REQ-013 Port: drop_cnt, output, NUM_CH*CNT_WIDTH, beats discarded per channel while frozen.
REQ-014 Port: timeout_err, output, NUM_CH, sticky per-channel forced-truncation flag.

Function
REQ-015 Each channel SHALL be independent, with one output register stage: m_* registered, s_tready = (~m_tvalid | m_tready) in RUN and DRAIN; latency from an accepted s beat to m_tvalid SHALL be 1 cycle.
REQ-016 Each channel SHALL track in_pkt: set on an accepted beat with s_tlast=0, cleared on an accepted beat with s_tlast=1.
REQ-017 Per-channel FSM states SHALL be RUN, DRAIN, TRUNC, FROZEN.
REQ-018 RUN: on pr_freeze=1 the channel SHALL go to FROZEN if in_pkt=0 (including when the beat accepted in that cycle has tlast=1), else to DRAIN; the drain counter SHALL be cleared.
REQ-019 DRAIN: traffic SHALL pass normally; the drain counter SHALL increment every cycle; an accepted s_tlast=1 beat SHALL move the channel to FROZEN.
REQ-020 DRAIN: pr_freeze=0 SHALL return the channel to RUN with in_pkt preserved, which aborts the freeze.
REQ-021 DRAIN: when the counter reaches DRAIN_TIMEOUT-1 with no tlast accepted, the channel SHALL enter TRUNC and set timeout_err.
REQ-022 TRUNC: s_tready SHALL be 0; once the output register is free, one beat SHALL be injected with tdata=0, tuser=0, tlast=1; in_pkt SHALL then clear and the channel SHALL go to FROZEN; pr_freeze SHALL be ignored in TRUNC.
REQ-023 FROZEN: s_tready SHALL be 1 and accepted beats SHALL be discarded; the output register SHALL drain normally; no new m_tvalid SHALL be generated.
REQ-024 FROZEN: drop_cnt SHALL increment by 1 per discarded beat and saturate at all-ones.
REQ-025 FROZEN: on pr_freeze=0 the channel SHALL go to RUN with in_pkt cleared; the first beat accepted afterwards starts a new packet.
REQ-026 freeze_ack SHALL be registered and assert 1 cycle after every channel is in FROZEN with m_tvalid=0; it SHALL deassert 1 cycle after pr_freeze falls.
REQ-027 m_tdata, m_tuser, and m_tlast SHALL hold stable while m_tvalid=1 and m_tready=0 (AXI-S rules).
REQ-028 timeout_err SHALL be sticky until reset; drop_cnt SHALL not clear on freeze exit.

Reset
REQ-029 On reset assertion, asynchronously: FSMs to RUN; in_pkt, drain counters, m_tvalid, m_tlast, freeze_ack, drop_cnt, and timeout_err to 0; s_tready to 0 while reset is high.
REQ-030 Reset mid-packet or mid-freeze SHALL discard all state with no truncation beat emitted; after release, normal RUN behaviour begins the next cycle.

Verification
REQ-031 Idle freeze: NUM_CH=2, no traffic, pr_freeze=1 -> freeze_ack=1 two cycles later; drop_cnt=0.
REQ-032 Drain to boundary: 4-beat packet in flight at beat 2, freeze asserted -> beats 3-4 pass with tlast on beat 4, FROZEN, then freeze_ack; timeout_err=0.
REQ-033 Timeout: DRAIN_TIMEOUT=8, packet stalled without tlast -> exactly one zero beat with tlast=1 emitted; timeout_err[c]=1; freeze_ack asserts.
REQ-034 Frozen discard: 5 beats offered while frozen -> s_tready=1, m_tvalid=0, drop_cnt=5; CNT_WIDTH=2 with 5 beats -> saturates at 3.
REQ-035 Abort and backpressure: freeze asserted then dropped during DRAIN with m_tready=0 -> no beat lost or duplicated, channel back in RUN, freeze_ack never asserted.
REQ-036 Async reset during TRUNC -> all outputs 0 immediately; no injected beat after release.
